// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter paced by external baud ticks
module uart_tx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               overflow,
  input  logic               clk_bps,
  output logic               bps_start,
  output logic               rs232_tx,
  output logic               tx_busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  logic [7:0]         mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [1:0]         state;
  logic [7:0]         shift;
  logic [3:0]         bit_cnt;
  logic               push, pop;
  assign full    = level == DEPTH;
  assign push    = wr_en && !full;
  assign pop     = state == IDLE && level != '0;
  assign tx_busy = state == SEND;
  // byte storage; contents need no reset since level gates every read
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wr_data;
  // pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
      if (wr_en && full) overflow <= 1'b1;
    end
  // frame sequencer: tick 1 start bit, 2..9 data LSB first, 10 stop bit, 11 ends frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      bps_start <= 1'b0;
      rs232_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shift     <= mem[rptr];
          bit_cnt   <= '0;
          bps_start <= 1'b1;
          state     <= SEND;
        end
        SEND: if (clk_bps) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 4'd0) rs232_tx <= 1'b0;
          else if (bit_cnt <= 4'd8) begin
            rs232_tx <= shift[0];
            shift    <= shift >> 1;
          end else if (bit_cnt == 4'd9) rs232_tx <= 1'b1;
          else begin
            bps_start <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
